// File: rtl/jtag_pkg.sv
// Shared JTAG definitions: TAP state codes, opcodes and the state-to-strobe decode.
// Imported by the TAP controller, the instruction register and the data registers.
package jtag_pkg;

  typedef enum logic [3:0] {
    ST_EX2_DR   = 4'h0,
    ST_EX1_DR   = 4'h1,
    ST_SHIFT_DR = 4'h2,
    ST_PAUSE_DR = 4'h3,
    ST_SEL_IR   = 4'h4,
    ST_UPD_DR   = 4'h5,
    ST_CAP_DR   = 4'h6,
    ST_SEL_DR   = 4'h7,
    ST_EX2_IR   = 4'h8,
    ST_EX1_IR   = 4'h9,
    ST_SHIFT_IR = 4'hA,
    ST_PAUSE_IR = 4'hB,
    ST_RTI      = 4'hC,
    ST_UPD_IR   = 4'hD,
    ST_CAP_IR   = 4'hE,
    ST_TLR      = 4'hF
  } tapState_e;

  localparam logic [3:0] BYPASS_OPCODE = 4'hF;

  typedef struct packed {
    logic tlr;
    logic rti;
    logic captureIr;
    logic shiftIr;
    logic updateIr;
    logic captureDr;
    logic shiftDr;
    logic updateDr;
    logic selectIr;
  } tapFlags_t;

  // Moore decode; the IR column runs from Select-IR-Scan through Update-IR.
  function automatic tapFlags_t decodeState(input tapState_e s);
    tapFlags_t f;
    f = '0;
    case (s)
      ST_TLR:      f.tlr = 1'b1;
      ST_RTI:      f.rti = 1'b1;
      ST_CAP_DR:   f.captureDr = 1'b1;
      ST_SHIFT_DR: f.shiftDr = 1'b1;
      ST_UPD_DR:   f.updateDr = 1'b1;
      ST_SEL_IR, ST_EX1_IR, ST_PAUSE_IR, ST_EX2_IR: f.selectIr = 1'b1;
      ST_CAP_IR: begin
        f.captureIr = 1'b1;
        f.selectIr  = 1'b1;
      end
      ST_SHIFT_IR: begin
        f.shiftIr  = 1'b1;
        f.selectIr = 1'b1;
      end
      ST_UPD_IR: begin
        f.updateIr = 1'b1;
        f.selectIr = 1'b1;
      end
      default: f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// IEEE 1149.1 TAP controller: 16-state TMS-driven FSM with registered strobes,
// TDO steering and a falling-edge TDO output enable.
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  input  logic       INSTR_TDO,
  input  logic       DR_TDO,
  output logic [3:0] STATE,
  output logic       TEST_LOGIC_RESET,
  output logic       RUN_TEST_IDLE,
  output logic       CAPTUREIR,
  output logic       SHIFTIR,
  output logic       UPDATEIR,
  output logic       CAPTUREDR,
  output logic       SHIFTDR,
  output logic       UPDATEDR,
  output logic       SELECT_IR,
  output logic       TDO,
  output logic       TDO_EN
);

  tapState_e state_q, state_d;
  tapFlags_t flags_q;
  logic      tdo_en_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_TLR:      state_d = TMS ? ST_TLR      : ST_RTI;
      ST_RTI:      state_d = TMS ? ST_SEL_DR   : ST_RTI;
      ST_SEL_DR:   state_d = TMS ? ST_SEL_IR   : ST_CAP_DR;
      ST_CAP_DR:   state_d = TMS ? ST_EX1_DR   : ST_SHIFT_DR;
      ST_SHIFT_DR: state_d = TMS ? ST_EX1_DR   : ST_SHIFT_DR;
      ST_EX1_DR:   state_d = TMS ? ST_UPD_DR   : ST_PAUSE_DR;
      ST_PAUSE_DR: state_d = TMS ? ST_EX2_DR   : ST_PAUSE_DR;
      ST_EX2_DR:   state_d = TMS ? ST_UPD_DR   : ST_SHIFT_DR;
      ST_UPD_DR:   state_d = TMS ? ST_SEL_DR   : ST_RTI;
      ST_SEL_IR:   state_d = TMS ? ST_TLR      : ST_CAP_IR;
      ST_CAP_IR:   state_d = TMS ? ST_EX1_IR   : ST_SHIFT_IR;
      ST_SHIFT_IR: state_d = TMS ? ST_EX1_IR   : ST_SHIFT_IR;
      ST_EX1_IR:   state_d = TMS ? ST_UPD_IR   : ST_PAUSE_IR;
      ST_PAUSE_IR: state_d = TMS ? ST_EX2_IR   : ST_PAUSE_IR;
      ST_EX2_IR:   state_d = TMS ? ST_UPD_IR   : ST_SHIFT_IR;
      ST_UPD_IR:   state_d = TMS ? ST_SEL_DR   : ST_RTI;
      default:     state_d = ST_TLR;
    endcase
  end

  // Strobes are decoded from the next state so they register alongside it.
  always_ff @(posedge TCK) begin
    if (TRST) begin
      state_q <= ST_TLR;
      flags_q <= decodeState(ST_TLR);
    end else begin
      state_q <= state_d;
      flags_q <= decodeState(state_d);
    end
  end

  always_ff @(negedge TCK) begin
    if (TRST) tdo_en_q <= 1'b0;
    else      tdo_en_q <= flags_q.shiftIr | flags_q.shiftDr;
  end

  assign STATE            = state_q;
  assign TEST_LOGIC_RESET = flags_q.tlr;
  assign RUN_TEST_IDLE    = flags_q.rti;
  assign CAPTUREIR        = flags_q.captureIr;
  assign SHIFTIR          = flags_q.shiftIr;
  assign UPDATEIR         = flags_q.updateIr;
  assign CAPTUREDR        = flags_q.captureDr;
  assign SHIFTDR          = flags_q.shiftDr;
  assign UPDATEDR         = flags_q.updateDr;
  assign SELECT_IR        = flags_q.selectIr;
  assign TDO              = flags_q.selectIr ? INSTR_TDO : DR_TDO;
  assign TDO_EN           = tdo_en_q;

endmodule
